decode_stage: RTL and testbench



---
 rtl/decode_stage.sv | 196 +++++++++++++++++++
 tb/tb_decode_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: decodes the IF/ID instruction, reads the 32x32 register file,
// resolves branch/jump/jr/trap redirects to fetch and loads the ID/EX register.
// Latency: id_if_* combinational from IF/ID and state; ID/EX outputs 1 clock.
// Backpressure: none; a new instruction is accepted every clock.
// Optional feature: define ID_BYPASS_EN to forward same-cycle writeback data
// into rs/rt reads; otherwise reads return the pre-write register value.
// Ports: clock/reset (async, active-low); if_id_* instruction in; id_if_* redirect
// out; wb_id_* register-file write port; id_ex_* pipeline register; id_epc.
module decode_stage #(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0040
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] if_id_nextpc,
  input  logic [31:0] if_id_instruc,
  output logic        id_if_selpcsource,
  output logic [1:0]  id_if_selpctype,
  output logic [31:0] id_if_rega,
  output logic [31:0] id_if_pcimd2ext,
  output logic [31:0] id_if_pcindex,
  input  logic        wb_id_we,
  input  logic [4:0]  wb_id_waddr,
  input  logic [31:0] wb_id_wdata,
  output logic [31:0] id_ex_rega,
  output logic [31:0] id_ex_regb,
  output logic [31:0] id_ex_imm,
  output logic [5:0]  id_ex_op,
  output logic [5:0]  id_ex_funct,
  output logic [4:0]  id_ex_rd,
  output logic        id_ex_regwrite,
  output logic        id_ex_memread,
  output logic        id_ex_memwrite,
  output logic [31:0] id_ex_nextpc,
  output logic [31:0] id_epc
);

  // A zero trap vector would alias the reset fetch address.
  if (TRAP_VECTOR == 32'h0) begin : g_bad_trap_vector
    $error("TRAP_VECTOR must be nonzero");
  end

  typedef enum logic [1:0] {RUN = 2'd0, SLOT = 2'd1, SQUASH = 2'd2} state_t;
  state_t state, state_nxt;

  logic [31:0] regs [32];

  // Field extraction
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  assign op    = if_id_instruc[31:26];
  assign rs    = if_id_instruc[25:21];
  assign rt    = if_id_instruc[20:16];
  assign rd    = if_id_instruc[15:11];
  assign funct = if_id_instruc[5:0];
  assign imm16 = if_id_instruc[15:0];

  logic is_r, is_jr, is_j, is_jal, is_beq, is_bne, is_addi, is_andi, is_ori;
  logic is_lui, is_lw, is_sw, legal;
  assign is_r    = (op == 6'h00);
  assign is_jr   = is_r && (funct == 6'h08);
  assign is_j    = (op == 6'h02);
  assign is_jal  = (op == 6'h03);
  assign is_beq  = (op == 6'h04);
  assign is_bne  = (op == 6'h05);
  assign is_addi = (op == 6'h08);
  assign is_andi = (op == 6'h0C);
  assign is_ori  = (op == 6'h0D);
  assign is_lui  = (op == 6'h0F);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2B);
  assign legal   = is_r | is_j | is_jal | is_beq | is_bne | is_addi | is_andi |
                   is_ori | is_lui | is_lw | is_sw;

  // Register reads; r0 is hardwired to zero
  logic [31:0] rega, regb;
`ifdef ID_BYPASS_EN
  always_comb begin
    rega = (rs == 5'd0) ? 32'h0 : regs[rs];
    regb = (rt == 5'd0) ? 32'h0 : regs[rt];
    if (wb_id_we && (wb_id_waddr == rs) && (rs != 5'd0)) rega = wb_id_wdata;
    if (wb_id_we && (wb_id_waddr == rt) && (rt != 5'd0)) regb = wb_id_wdata;
  end
`else
  assign rega = (rs == 5'd0) ? 32'h0 : regs[rs];
  assign regb = (rt == 5'd0) ? 32'h0 : regs[rt];
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (wb_id_we && (wb_id_waddr != 5'd0)) begin
      regs[wb_id_waddr] <= wb_id_wdata;
    end
  end

  // Redirect candidates, before FSM suppression
  logic taken;
  assign taken = (is_beq && (rega == regb)) || (is_bne && (rega != regb)) ||
                 is_j || is_jal || is_jr;

  assign id_if_rega      = rega;
  assign id_if_pcimd2ext = if_id_nextpc + {{16{imm16[15]}}, imm16};
  assign id_if_pcindex   = {if_id_nextpc[31:26], if_id_instruc[25:0]};

  always_comb begin
    if (!legal)              id_if_selpctype = 2'b11;
    else if (is_j || is_jal) id_if_selpctype = 2'b10;
    else if (is_jr)          id_if_selpctype = 2'b01;
    else                     id_if_selpctype = 2'b00;
  end

  // FSM: state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = RUN;
    if (state == RUN) begin
      if (!legal)     state_nxt = SQUASH;
      else if (taken) state_nxt = SLOT;
    end
  end

  // FSM: outputs. Illegal in SLOT is a silent bubble, in RUN it traps.
  logic bubble, trap;
  always_comb begin
    id_if_selpcsource = 1'b0;
    trap              = 1'b0;
    bubble            = 1'b0;
    case (state)
      RUN: begin
        id_if_selpcsource = taken || !legal;
        trap              = !legal;
        bubble            = !legal;
      end
      SLOT:    bubble = !legal;
      default: bubble = 1'b1;
    endcase
  end

  // ID/EX field values for a non-bubble instruction
  logic [31:0] imm_ext;
  always_comb begin
    if (is_andi || is_ori) imm_ext = {16'h0, imm16};
    else if (is_lui)       imm_ext = {imm16, 16'h0};
    else                   imm_ext = {{16{imm16[15]}}, imm16};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      id_ex_rega     <= 32'h0;
      id_ex_regb     <= 32'h0;
      id_ex_imm      <= 32'h0;
      id_ex_op       <= 6'h0;
      id_ex_funct    <= 6'h0;
      id_ex_rd       <= 5'h0;
      id_ex_regwrite <= 1'b0;
      id_ex_memread  <= 1'b0;
      id_ex_memwrite <= 1'b0;
      id_ex_nextpc   <= 32'h0;
      id_epc         <= 32'h0;
    end else begin
      if (trap) id_epc <= if_id_nextpc - 32'd1;
      if (bubble) begin
        id_ex_rega     <= 32'h0;
        id_ex_regb     <= 32'h0;
        id_ex_imm      <= 32'h0;
        id_ex_op       <= 6'h0;
        id_ex_funct    <= 6'h0;
        id_ex_rd       <= 5'h0;
        id_ex_regwrite <= 1'b0;
        id_ex_memread  <= 1'b0;
        id_ex_memwrite <= 1'b0;
        id_ex_nextpc   <= 32'h0;
      end else begin
        // jal links past its delay slot
        id_ex_rega     <= is_jal ? (if_id_nextpc + 32'd1) : rega;
        id_ex_regb     <= regb;
        id_ex_imm      <= imm_ext;
        id_ex_op       <= op;
        id_ex_funct    <= funct;
        id_ex_rd       <= is_jal ? 5'd31 : (is_r ? rd : rt);
        id_ex_regwrite <= (is_r && !is_jr) || is_jal || is_addi || is_andi ||
                          is_ori || is_lui || is_lw;
        id_ex_memread  <= is_lw;
        id_ex_memwrite <= is_sw;
        id_ex_nextpc   <= if_id_nextpc;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] if_id_nextpc, if_id_instruc;
  logic        id_if_selpcsource;
  logic [1:0]  id_if_selpctype;
  logic [31:0] id_if_rega, id_if_pcimd2ext, id_if_pcindex;
  logic        wb_id_we;
  logic [4:0]  wb_id_waddr;
  logic [31:0] wb_id_wdata;
  logic [31:0] id_ex_rega, id_ex_regb, id_ex_imm, id_ex_nextpc, id_epc;
  logic [5:0]  id_ex_op, id_ex_funct;
  logic [4:0]  id_ex_rd;
  logic        id_ex_regwrite, id_ex_memread, id_ex_memwrite;

  decode_stage dut (
    .clock(clock), .reset(reset),
    .if_id_nextpc(if_id_nextpc), .if_id_instruc(if_id_instruc),
    .id_if_selpcsource(id_if_selpcsource), .id_if_selpctype(id_if_selpctype),
    .id_if_rega(id_if_rega), .id_if_pcimd2ext(id_if_pcimd2ext),
    .id_if_pcindex(id_if_pcindex),
    .wb_id_we(wb_id_we), .wb_id_waddr(wb_id_waddr), .wb_id_wdata(wb_id_wdata),
    .id_ex_rega(id_ex_rega), .id_ex_regb(id_ex_regb), .id_ex_imm(id_ex_imm),
    .id_ex_op(id_ex_op), .id_ex_funct(id_ex_funct), .id_ex_rd(id_ex_rd),
    .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
    .id_ex_memwrite(id_ex_memwrite), .id_ex_nextpc(id_ex_nextpc), .id_epc(id_epc)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] rega, regb, imm;
    logic [5:0]  op, funct;
    logic [4:0]  rd;
    logic        rw, mr, mw;
    logic [31:0] nextpc;
  } idex_t;

  typedef struct { bit chk; idex_t v; } sb_t;

  sb_t q[$];
  int checks = 0;
  int failures = 0;

`ifdef ID_BYPASS_EN
  localparam logic [31:0] JR_EXP = 32'h0000_ABCD;
`else
  localparam logic [31:0] JR_EXP = 32'h0000_1234;
`endif

  function automatic idex_t mk(logic [31:0] ra, logic [31:0] rb, logic [31:0] im,
                               logic [5:0] o, logic [5:0] f, logic [4:0] d,
                               logic w, logic r, logic m, logic [31:0] npc);
    idex_t e;
    e.rega = ra; e.regb = rb; e.imm = im; e.op = o; e.funct = f; e.rd = d;
    e.rw = w; e.mr = r; e.mw = m; e.nextpc = npc;
    return e;
  endfunction

  function automatic idex_t dut_idex();
    return mk(id_ex_rega, id_ex_regb, id_ex_imm, id_ex_op, id_ex_funct, id_ex_rd,
              id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_nextpc);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(logic [31:0] npc, logic [31:0] ins,
                       logic we, logic [4:0] wa, logic [31:0] wd);
    @(negedge clock);
    if_id_nextpc = npc; if_id_instruc = ins;
    wb_id_we = we; wb_id_waddr = wa; wb_id_wdata = wd;
    #1;
  endtask

  task automatic push(bit c, idex_t v);
    sb_t e;
    e.chk = c; e.v = v;
    q.push_back(e);
  endtask

  // Monitor: ID/EX presents a new result every clock after stimulus
  initial begin
    sb_t e;
    idex_t act;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          act = dut_idex();
          checks++;
          if (act !== e.v) begin
            failures++;
            $display("FAIL idex npc=%h actual=%h required=%h", e.v.nextpc, act, e.v);
          end
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    if_id_nextpc = '0; if_id_instruc = '0;
    wb_id_we = 1'b0; wb_id_waddr = '0; wb_id_wdata = '0;
    repeat (2) @(negedge clock);
    #1;
    check("reset_idex_zero", 32'(dut_idex() != '0), 32'd0);
    check("reset_epc", id_epc, 32'h0);
    check("reset_sel", 32'(id_if_selpcsource), 32'd0);
    @(negedge clock); reset = 1'b1;

    drive(32'h0, 32'h0, 1'b1, 5'd1, 32'd5); push(0, '0);
    drive(32'h0, 32'h0, 1'b1, 5'd2, 32'd5); push(0, '0);

    // beq r1,r2,+3 taken
    drive(32'h10, 32'h1022_0003, 1'b0, 5'd0, 32'd0);
    check("beq_sel", 32'(id_if_selpcsource), 32'd1);
    check("beq_type", 32'(id_if_selpctype), 32'd0);
    check("beq_target", id_if_pcimd2ext, 32'h13);
    push(1, mk(5, 5, 3, 6'h04, 6'h03, 5'd2, 0, 0, 0, 32'h10));

    // taken beq in the delay slot is suppressed but still executes
    drive(32'h11, 32'h1022_0003, 1'b0, 5'd0, 32'd0);
    check("slot_suppress", 32'(id_if_selpcsource), 32'd0);
    push(1, mk(5, 5, 3, 6'h04, 6'h03, 5'd2, 0, 0, 0, 32'h11));

    // bne with equal operands: not taken
    drive(32'h12, 32'h1422_0005, 1'b0, 5'd0, 32'd0);
    check("bne_not_taken", 32'(id_if_selpcsource), 32'd0);
    check("bne_target", id_if_pcimd2ext, 32'h17);
    push(1, mk(5, 5, 5, 6'h05, 6'h05, 5'd2, 0, 0, 0, 32'h12));

    // j then jal in its delay slot
    drive(32'h0400_0008, 32'h0800_0020, 1'b0, 5'd0, 32'd0);
    check("j_sel", 32'(id_if_selpcsource), 32'd1);
    check("j_type", 32'(id_if_selpctype), 32'd2);
    check("j_index", id_if_pcindex, 32'h0400_0020);
    push(1, mk(0, 0, 32'h20, 6'h02, 6'h20, 5'd0, 0, 0, 0, 32'h0400_0008));
    drive(32'h0400_0009, 32'h0C00_0030, 1'b0, 5'd0, 32'd0);
    check("jal_slot_sel", 32'(id_if_selpcsource), 32'd0);
    push(1, mk(32'h0400_000A, 0, 32'h30, 6'h03, 6'h30, 5'd31, 1, 0, 0, 32'h0400_0009));

    // illegal opcode traps, next instruction squashed
    drive(32'h21, 32'hFC00_0000, 1'b0, 5'd0, 32'd0);
    check("trap_sel", 32'(id_if_selpcsource), 32'd1);
    check("trap_type", 32'(id_if_selpctype), 32'd3);
    push(1, '0);
    drive(32'h22, 32'h2024_0007, 1'b0, 5'd0, 32'd0);
    check("trap_epc", id_epc, 32'h20);
    check("squash_sel", 32'(id_if_selpcsource), 32'd0);
    push(1, '0);

    // immediate forms and memory ops in RUN
    drive(32'h23, 32'h2024_0007, 1'b0, 5'd0, 32'd0);
    push(1, mk(5, 0, 32'h7, 6'h08, 6'h07, 5'd4, 1, 0, 0, 32'h23));
    drive(32'h24, 32'h3C05_8001, 1'b0, 5'd0, 32'd0);
    push(1, mk(0, 0, 32'h8001_0000, 6'h0F, 6'h01, 5'd5, 1, 0, 0, 32'h24));
    drive(32'h25, 32'h3026_8000, 1'b0, 5'd0, 32'd0);
    push(1, mk(5, 0, 32'h0000_8000, 6'h0C, 6'h00, 5'd6, 1, 0, 0, 32'h25));
    drive(32'h26, 32'h3428_FFFF, 1'b0, 5'd0, 32'd0);
    push(1, mk(5, 0, 32'h0000_FFFF, 6'h0D, 6'h3F, 5'd8, 1, 0, 0, 32'h26));
    drive(32'h27, 32'h8C27_FFFC, 1'b0, 5'd0, 32'd0);
    push(1, mk(5, 0, 32'hFFFF_FFFC, 6'h23, 6'h3C, 5'd7, 1, 1, 0, 32'h27));
    drive(32'h28, 32'hAC22_0008, 1'b0, 5'd0, 32'd0);
    push(1, mk(5, 5, 32'h8, 6'h2B, 6'h08, 5'd2, 0, 0, 1, 32'h28));

    // same-cycle writeback of r3 while jr r3 decodes
    drive(32'h30, 32'h0, 1'b1, 5'd3, 32'h1234); push(0, '0);
    drive(32'h40, 32'h0060_0008, 1'b1, 5'd3, 32'hABCD);
    check("jr_rega", id_if_rega, JR_EXP);
    check("jr_sel", 32'(id_if_selpcsource), 32'd1);
    check("jr_type", 32'(id_if_selpctype), 32'd1);
    push(1, mk(JR_EXP, 0, 32'h8, 6'h00, 6'h08, 5'd0, 0, 0, 0, 32'h40));
    drive(32'h41, 32'h0, 1'b0, 5'd0, 32'd0); push(0, '0);

    // trap into SQUASH, then reset mid-operation
    drive(32'h42, 32'hFC00_0000, 1'b0, 5'd0, 32'd0);
    push(1, '0);
    @(negedge clock);
    if_id_instruc = 32'h0;
    reset = 1'b0;
    #1;
    check("midreset_idex_zero", 32'(dut_idex() != '0), 32'd0);
    check("midreset_epc", id_epc, 32'h0);
    @(negedge clock); reset = 1'b1;

    // first instruction after reset decodes in RUN (register file now zero)
    drive(32'h50, 32'h1022_0003, 1'b0, 5'd0, 32'd0);
    check("post_reset_run", 32'(id_if_selpcsource), 32'd1);
    push(1, mk(0, 0, 3, 6'h04, 6'h03, 5'd2, 0, 0, 0, 32'h50));
    drive(32'h51, 32'h0, 1'b0, 5'd0, 32'd0); push(0, '0);

    repeat (2) @(negedge clock);
    check("scoreboard_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
